// File: rtl/acc_unit.sv
// acc_unit: accumulator register for the accumulator processor datapath.
// Supports load, add, subtract, shift left/right and a small save/restore stack
// for subroutine and interrupt context.
// One op per cycle. The result appears on the outputs after the rising edge
// that samples op.
//
// Ports:
//   clk          rising-edge clock
//   reset        asynchronous, active-high; clears all state except stack contents
//   op[2:0]      0 HOLD, 1 LOAD, 2 ADD, 3 SUB, 4 SHL, 5 SHR, 6 PUSH, 7 POP
//   din          operand for LOAD/ADD/SUB
//   acc_out      registered accumulator
//   zero/neg     state of acc after the last op that updates these flags
//   carry        carry (ADD), borrow (SUB) or the bit shifted out (SHL/SHR)
//   ovf          signed overflow from ADD/SUB; cleared by shifts
//   stack_count  number of occupied stack entries
//   stack_full   stack_count == STACK_DEPTH
//   stack_empty  stack_count == 0
//   err          one-cycle pulse on PUSH when full or POP when empty
module acc_unit #(
  parameter int WIDTH       = 16,
  parameter int STACK_DEPTH = 4,
  parameter bit SATURATE    = 1'b0
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [2:0]                       op,
  input  logic [WIDTH-1:0]                 din,
  output logic [WIDTH-1:0]                 acc_out,
  output logic                             zero,
  output logic                             neg,
  output logic                             carry,
  output logic                             ovf,
  output logic [$clog2(STACK_DEPTH+1)-1:0] stack_count,
  output logic                             stack_full,
  output logic                             stack_empty,
  output logic                             err
);

  localparam int CW = $clog2(STACK_DEPTH+1);
  // Stack index width; a depth of 1 still needs one address bit.
  localparam int IW = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

  localparam logic [WIDTH-1:0] SMAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] SMIN = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [2:0] {
    OP_HOLD = 3'b000,
    OP_LOAD = 3'b001,
    OP_ADD  = 3'b010,
    OP_SUB  = 3'b011,
    OP_SHL  = 3'b100,
    OP_SHR  = 3'b101,
    OP_PUSH = 3'b110,
    OP_POP  = 3'b111
  } op_e;

  op_e opc;
  assign opc = op_e'(op);

  // Save stack. Its contents are not reset: only the count says what is valid.
  logic [WIDTH-1:0] stack_mem [STACK_DEPTH];

  // Arithmetic. The extra top bit gives the carry for ADD and the borrow for SUB.
  logic [WIDTH:0]   add_x, sub_x;
  logic             add_ovf, sub_ovf;
  logic [WIDTH-1:0] sat_val;
  logic             msb_a, msb_d;

  assign msb_a   = acc_out[WIDTH-1];
  assign msb_d   = din[WIDTH-1];
  assign add_x   = {1'b0, acc_out} + {1'b0, din};
  assign sub_x   = {1'b0, acc_out} - {1'b0, din};
  assign add_ovf = (msb_a == msb_d) && (add_x[WIDTH-1] != msb_a);
  assign sub_ovf = (msb_a != msb_d) && (sub_x[WIDTH-1] != msb_a);
  // In both cases the true result has the sign of acc. For ADD the operands
  // share that sign. For SUB, acc - (opposite sign) moves away from zero.
  assign sat_val = msb_a ? SMIN : SMAX;

  // Stack bookkeeping
  logic          full_c, empty_c, push_ok, pop_ok, stk_err;
  logic [CW-1:0] cnt_dec;
  logic [IW-1:0] wr_idx, rd_idx;

  assign full_c  = (stack_count == CW'(STACK_DEPTH));
  assign empty_c = (stack_count == '0);
  assign push_ok = (opc == OP_PUSH) && !full_c;
  assign pop_ok  = (opc == OP_POP)  && !empty_c;
  assign stk_err = ((opc == OP_PUSH) && full_c) || ((opc == OP_POP) && empty_c);
  assign cnt_dec = stack_count - CW'(1);
  // These indices are only used while count < DEPTH (push) or count > 0 (pop),
  // so the low IW bits hold the exact value.
  assign wr_idx  = stack_count[IW-1:0];
  assign rd_idx  = cnt_dec[IW-1:0];

  assign stack_full  = full_c;
  assign stack_empty = empty_c;

  // Next state
  logic [WIDTH-1:0] acc_nx;
  logic             carry_nx, ovf_nx, upd_zn;
  logic [CW-1:0]    cnt_nx;

  always_comb begin
    acc_nx   = acc_out;
    carry_nx = carry;
    ovf_nx   = ovf;
    cnt_nx   = stack_count;
    upd_zn   = 1'b0;
    unique case (opc)
      OP_HOLD: ;
      OP_LOAD: begin
        acc_nx = din;
        upd_zn = 1'b1;
      end
      OP_ADD: begin
        carry_nx = add_x[WIDTH];
        ovf_nx   = add_ovf;
        acc_nx   = (SATURATE && add_ovf) ? sat_val : add_x[WIDTH-1:0];
        upd_zn   = 1'b1;
      end
      OP_SUB: begin
        carry_nx = sub_x[WIDTH];
        ovf_nx   = sub_ovf;
        acc_nx   = (SATURATE && sub_ovf) ? sat_val : sub_x[WIDTH-1:0];
        upd_zn   = 1'b1;
      end
      OP_SHL: begin
        carry_nx = msb_a;
        ovf_nx   = 1'b0;
        acc_nx   = {acc_out[WIDTH-2:0], 1'b0};
        upd_zn   = 1'b1;
      end
      OP_SHR: begin
        carry_nx = acc_out[0];
        ovf_nx   = 1'b0;
        acc_nx   = {msb_a, acc_out[WIDTH-1:1]};
        upd_zn   = 1'b1;
      end
      OP_PUSH: begin
        if (push_ok) cnt_nx = stack_count + CW'(1);
      end
      OP_POP: begin
        if (pop_ok) begin
          cnt_nx = cnt_dec;
          acc_nx = stack_mem[rd_idx];
          upd_zn = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_out     <= '0;
      zero        <= 1'b1;
      neg         <= 1'b0;
      carry       <= 1'b0;
      ovf         <= 1'b0;
      stack_count <= '0;
      err         <= 1'b0;
    end else begin
      acc_out     <= acc_nx;
      carry       <= carry_nx;
      ovf         <= ovf_nx;
      stack_count <= cnt_nx;
      err         <= stk_err;
      if (upd_zn) begin
        zero <= (acc_nx == '0);
        neg  <= acc_nx[WIDTH-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) stack_mem[wr_idx] <= acc_out;
  end

endmodule

// File: tb/tb_acc_unit.sv
module tb_acc_unit;
  localparam int W = 16;
  localparam int D = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  op;
  logic [15:0] din;

  logic [15:0] acc_o [2];
  logic [2:0]  cnt_o [2];
  logic [1:0]  z_o, n_o, c_o, v_o, full_o, empty_o, err_o;

  always #5 clk = ~clk;

  // Instance 0 wraps on overflow; instance 1 saturates.
  acc_unit #(.WIDTH(W), .STACK_DEPTH(D), .SATURATE(1'b0)) u_wrap (
    .clk(clk), .reset(reset), .op(op), .din(din),
    .acc_out(acc_o[0]), .zero(z_o[0]), .neg(n_o[0]), .carry(c_o[0]), .ovf(v_o[0]),
    .stack_count(cnt_o[0]), .stack_full(full_o[0]), .stack_empty(empty_o[0]),
    .err(err_o[0]));

  acc_unit #(.WIDTH(W), .STACK_DEPTH(D), .SATURATE(1'b1)) u_sat (
    .clk(clk), .reset(reset), .op(op), .din(din),
    .acc_out(acc_o[1]), .zero(z_o[1]), .neg(n_o[1]), .carry(c_o[1]), .ovf(v_o[1]),
    .stack_count(cnt_o[1]), .stack_full(full_o[1]), .stack_empty(empty_o[1]),
    .err(err_o[1]));

  typedef struct packed {
    logic [15:0] acc;
    logic        z, n, c, v;
    logic [2:0]  cnt;
    logic        err;
  } exp_t;

  exp_t q0[$], q1[$];
  exp_t e0, e1;
  int   checks = 0;
  int   errors = 0;

  // Reference model: plain integer arithmetic per instance.
  int m_acc [2];
  int m_cnt [2];
  int m_stk [2][D];
  bit m_z [2], m_n [2], m_c [2], m_v [2], m_err [2];

  function automatic int sx(input int v);
    return (v >= 32768) ? v - 65536 : v;
  endfunction

  function automatic exp_t mexp(input int k);
    exp_t e;
    e.acc = 16'(m_acc[k]);
    e.z   = m_z[k];
    e.n   = m_n[k];
    e.c   = m_c[k];
    e.v   = m_v[k];
    e.cnt = 3'(m_cnt[k]);
    e.err = m_err[k];
    return e;
  endfunction

  task automatic mreset();
    for (int k = 0; k < 2; k++) begin
      m_acc[k] = 0; m_z[k] = 1; m_n[k] = 0; m_c[k] = 0; m_v[k] = 0;
      m_cnt[k] = 0; m_err[k] = 0;
    end
  endtask

  task automatic mstep(input int k, input int o, input int d, input bit sat);
    int a, r;
    bit zn;
    a  = m_acc[k];
    zn = 0;
    m_err[k] = 0;
    case (o)
      1: begin a = d; zn = 1; end
      2: begin
        r = sx(m_acc[k]) + sx(d);
        m_c[k] = (m_acc[k] + d) > 65535;
        m_v[k] = (r > 32767) || (r < -32768);
        a = (sat && m_v[k]) ? ((r > 0) ? 32767 : 32768) : (m_acc[k] + d) % 65536;
        zn = 1;
      end
      3: begin
        r = sx(m_acc[k]) - sx(d);
        m_c[k] = m_acc[k] < d;
        m_v[k] = (r > 32767) || (r < -32768);
        a = (sat && m_v[k]) ? ((r > 0) ? 32767 : 32768) : (m_acc[k] - d + 65536) % 65536;
        zn = 1;
      end
      4: begin
        m_c[k] = m_acc[k] >= 32768;
        m_v[k] = 0;
        a = (m_acc[k] * 2) % 65536;
        zn = 1;
      end
      5: begin
        m_c[k] = (m_acc[k] % 2) == 1;
        m_v[k] = 0;
        r = sx(m_acc[k]);
        r = (r - ((r % 2 + 2) % 2)) / 2;   // floor(r/2)
        a = (r + 65536) % 65536;
        zn = 1;
      end
      6: begin
        if (m_cnt[k] == D) m_err[k] = 1;
        else begin m_stk[k][m_cnt[k]] = m_acc[k]; m_cnt[k]++; end
      end
      7: begin
        if (m_cnt[k] == 0) m_err[k] = 1;
        else begin m_cnt[k]--; a = m_stk[k][m_cnt[k]]; zn = 1; end
      end
      default: ;
    endcase
    m_acc[k] = a;
    if (zn) begin m_z[k] = (a == 0); m_n[k] = (a >= 32768); end
  endtask

  task automatic check(input int k, input exp_t e, input string nm);
    exp_t a;
    a = {acc_o[k], z_o[k], n_o[k], c_o[k], v_o[k], cnt_o[k], err_o[k]};
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s sat%0d: got acc=%h z=%b n=%b c=%b v=%b cnt=%0d err=%b, want acc=%h z=%b n=%b c=%b v=%b cnt=%0d err=%b",
               nm, k, a.acc, a.z, a.n, a.c, a.v, a.cnt, a.err,
               e.acc, e.z, e.n, e.c, e.v, e.cnt, e.err);
    end
    checks++;
    if (full_o[k] !== (e.cnt == 3'(D)) || empty_o[k] !== (e.cnt == 3'd0)) begin
      errors++;
      $display("FAIL %s_fullempty sat%0d: got full=%b empty=%b, want cnt=%0d",
               nm, k, full_o[k], empty_o[k], e.cnt);
    end
  endtask

  // Monitor: the output of the op applied at this edge is checked at the
  // following negedge.
  always @(posedge clk) begin
    if (q0.size() > 0) begin
      e0 = q0.pop_front();
      e1 = q1.pop_front();
      @(negedge clk);
      check(0, e0, "op");
      check(1, e1, "op");
    end
  end

  task automatic do_op(input logic [2:0] o, input logic [15:0] d);
    @(posedge clk);
    #1;
    op  = o;
    din = d;
    mstep(0, int'(o), int'(d), 1'b0);
    mstep(1, int'(o), int'(d), 1'b1);
    q0.push_back(mexp(0));
    q1.push_back(mexp(1));
  endtask

  // Asserts reset between edges and checks that the outputs clear at once.
  task automatic reset_check();
    @(posedge clk);
    #1 op = 3'd0;
    @(negedge clk);
    #1 reset = 1'b1;
    #1;
    mreset();
    check(0, mexp(0), "async_reset");
    check(1, mexp(1), "async_reset");
    @(negedge clk);
    reset = 1'b0;
  endtask

  localparam int ND = 30;
  localparam logic [18:0] DIR [ND] = '{
    {3'd1, 16'h7FFF}, {3'd2, 16'h0001}, {3'd2, 16'h8000},
    {3'd1, 16'h7FFF}, {3'd2, 16'h0001},
    {3'd1, 16'h8000}, {3'd3, 16'h0001},
    {3'd1, 16'h0005}, {3'd3, 16'h0007},
    {3'd1, 16'h8001}, {3'd4, 16'h0000}, {3'd5, 16'h0000},
    {3'd1, 16'h8000}, {3'd5, 16'h0000},
    {3'd1, 16'h0011}, {3'd6, 16'h0000}, {3'd1, 16'h0022}, {3'd6, 16'h0000},
    {3'd1, 16'h0033}, {3'd6, 16'h0000}, {3'd1, 16'h0044}, {3'd6, 16'h0000},
    {3'd6, 16'h0000},
    {3'd7, 16'h0000}, {3'd7, 16'h0000}, {3'd7, 16'h0000}, {3'd7, 16'h0000},
    {3'd7, 16'h0000},
    {3'd1, 16'h0011}, {3'd6, 16'h0000}
  };

  // Watchdog
  initial begin
    repeat (50000) @(posedge clk);
    $display("FAIL watchdog: simulation did not finish within the cycle budget");
    $fatal(1, "timeout");
  end

  initial begin
    logic [18:0] ent;
    op    = 3'd0;
    din   = '0;
    reset = 1'b1;
    mreset();
    #2;
    check(0, mexp(0), "reset");
    check(1, mexp(1), "reset");
    @(negedge clk);
    reset = 1'b0;

    // Directed sequence, with a HOLD after every op
    for (int i = 0; i < ND; i++) begin
      ent = DIR[i];
      do_op(ent[18:16], ent[15:0]);
      do_op(3'd0, 16'(i));
    end
    // Second push then a new acc value: acc=0x1234 with count=2, then reset mid-run
    do_op(3'd6, 16'h0);
    do_op(3'd1, 16'h1234);
    reset_check();

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      do_op(3'($urandom_range(0, 7)), 16'($urandom));
      if (i == 300) reset_check();
    end
    do_op(3'd0, 16'h0);

    // Drain the scoreboard, bounded
    for (int i = 0; i < 20 && q0.size() > 0; i++) @(posedge clk);
    @(negedge clk);
    #1;
    checks++;
    if (q0.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending, want 0", q0.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
